// File: rtl/mux_nx1_pipe_pkg.sv
// Shared constants for the pipelined N:1 mux: skid-buffer state encoding and
// default channel geometry.
package mux_nx1_pipe_pkg;

  typedef logic [1:0] skid_state_t;

  localparam skid_state_t ST_EMPTY = 2'b00;
  localparam skid_state_t ST_ONE   = 2'b01;
  localparam skid_state_t ST_FULL  = 2'b10;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NUM_IN = 4;

endpackage

// File: rtl/mux_nx1_comb.sv
// Combinational N:1 channel select; out-of-range selects yield FILL and are
// flagged so the pipeline can raise its sticky error.
module mux_nx1_comb
  import mux_nx1_pipe_pkg::*;
#(
  parameter int               WIDTH  = DEF_WIDTH,
  parameter int               NUM_IN = DEF_NUM_IN,
  parameter logic [WIDTH-1:0] FILL   = '0,
  localparam int              SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_illegal
);

  always_comb begin
    data_out    = FILL;
    sel_illegal = (int'(sel) >= NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) data_out = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// Pipelined N:1 mux: the selected channel is registered into a 2-entry skid
// buffer so in_ready never depends combinationally on out_ready.
module mux_nx1_pipe
  import mux_nx1_pipe_pkg::*;
#(
  parameter int               WIDTH  = DEF_WIDTH,
  parameter int               NUM_IN = DEF_NUM_IN,
  parameter logic [WIDTH-1:0] FILL   = '0,
  localparam int              SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr,
  output skid_state_t             state_dbg
);

  // Handshake: a beat moves across an interface only on a rising edge where
  // its valid and ready are both high; valid never waits on ready.
  skid_state_t      state;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] mux_data;
  logic             mux_illegal;
  logic             accept;
  logic             drain;

  mux_nx1_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .FILL   (FILL)
  ) u_mux (
    .in_data     (in_data),
    .sel         (in_sel),
    .data_out    (mux_data),
    .sel_illegal (mux_illegal)
  );

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = out_q;
  assign state_dbg = state;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_q <= mux_data;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({accept, drain})
            2'b11: out_q <= mux_data;
            2'b10: begin
              skid_q <= mux_data;
              state  <= ST_FULL;
            end
            2'b01: state <= ST_EMPTY;
            default: ;
          endcase
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            out_q <= skid_q;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // A new error outranks a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     sel_err <= 1'b0;
    else if (accept && mux_illegal) sel_err <= 1'b1;
    else if (err_clr)               sel_err <= 1'b0;
  end

endmodule

// File: doc/mux_nx1_pipe.md
MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, data width of every input channel and the output.
REQ-002 SHALL provide parameter NUM_IN, default 4, number of input channels, legal range 2..16.
REQ-003 SHALL provide parameter FILL, default 16'h0000, output value for an illegal select, sized WIDTH.
REQ-004 SHALL derive localparam SEL_W = clog2(NUM_IN), minimum 1.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_sel  input  SEL_W  channel select, sampled with in_data.
REQ-009 in_valid  input  1  upstream beat present.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 out_data  output  WIDTH  selected, registered data.
REQ-012 out_valid  output  1  out_data holds a beat.
REQ-013 out_ready  input  1  downstream accepts a beat.
REQ-014 sel_err  output  1  sticky: an accepted beat had in_sel >= NUM_IN.
REQ-015 err_clr  input  1  synchronous clear of sel_err.

Function
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both high at a rising edge.
REQ-017 An accepted beat SHALL carry channel in_sel, or FILL when in_sel >= NUM_IN; high-impedance SHALL never be driven.
REQ-018 The output SHALL be a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-019 Latency SHALL be one cycle: a beat accepted at edge N appears on out_data with out_valid high after edge N.
REQ-020 in_ready SHALL be high in EMPTY and ONE, low in FULL, and registered (no combinational path from out_ready).
REQ-021 EMPTY->ONE on accept; ONE->EMPTY on drain without accept; ONE stays ONE on simultaneous accept and drain; ONE->FULL on accept without drain; FULL->ONE on drain.
REQ-022 Drain SHALL mean out_valid and out_ready both high at an edge.
REQ-023 While out_valid is high and out_ready is low, out_data SHALL remain stable.
REQ-024 Beats SHALL leave in acceptance order; none dropped, none duplicated.
REQ-025 Sustained in_valid and out_ready high SHALL give one beat per cycle.
REQ-026 The skid entry SHALL move to the output register on the drain edge in FULL.
REQ-027 sel_err SHALL set on an accepted illegal-select beat and stay set until err_clr.
REQ-028 When err_clr coincides with a setting event, set SHALL win.
REQ-029 in_sel and in_data SHALL be ignored in cycles with no accept.

Reset
REQ-030 On rst_n low, out_valid=0, in_ready=1, sel_err=0, out_data=0, state=EMPTY, immediately and without a clock edge.
REQ-031 Reset mid-operation SHALL discard both buffered beats.
REQ-032 Deassertion SHALL take effect at the next rising edge; the first accept may occur at that edge.

Structure
REQ-033 The shared processor package SHALL hold the state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) and the default WIDTH/NUM_IN constants.
REQ-034 The combinational select SHALL be a sub-module, mux_nx1_comb, parametrised on WIDTH, NUM_IN and FILL; the skid buffer SHALL stay in the top module.

Verification
REQ-035 NUM_IN=4, channels 16'h1111/2222/3333/4444, sel 0..3 on consecutive cycles, out_ready=1 -> out_data 1111,2222,3333,4444 on consecutive cycles, each one cycle after accept.
REQ-036 sel=2'b11 with NUM_IN=3 -> out_data=FILL (16'h0000), sel_err=1 after that edge; err_clr pulse -> sel_err=0; simultaneous error and err_clr -> sel_err=1.
REQ-037 Accept A, B, C with out_ready=0 -> in_ready low after B, C stalls, out_data=A stable; raise out_ready -> A, B, C in order, no loss.
REQ-038 Random in_valid/out_ready at 50% over 1000 cycles -> output stream equals the reference model of accepted beats.
REQ-039 rst_n low while FULL -> out_valid=0, in_ready=1 without a clock edge; no pre-reset beat appears afterwards.
REQ-040 NUM_IN=16, WIDTH=8, all 16 selects -> each channel value delivered correctly.
